// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Optional watchdog on the memory transaction enabled by MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_start,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_start,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_size,
    input  logic              ls_op,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_size,
    output logic              mem_op,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t             r_state;
    state_t             w_next;
    logic               w_grant_if;
    logic               w_grant_ls;
    logic               w_timeout;
    logic               r_last_ls;
    logic               r_if_done;
    logic               r_ls_done;
    logic               r_err;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_mem_start;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [1:0]         r_mem_size;
    logic               r_mem_op;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [1:0]         r_grant;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] r_cnt;

    // Counts ISSUE cycles; held at zero elsewhere so every ISSUE starts from zero.
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_ISSUE)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_ISSUE) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    // Round-robin pick: on a tie the requester that did not win last time goes first.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_ls = 1'b0;
        if (r_state == S_IDLE) begin
            if (if_start && ls_start) begin
                w_grant_if = r_last_ls;
                w_grant_ls = ~r_last_ls;
            end else begin
                w_grant_if = if_start;
                w_grant_ls = ls_start;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_grant_if || w_grant_ls) w_next = S_ISSUE;
            S_ISSUE:   if (mem_done || w_timeout)    w_next = S_DONE;
            S_DONE:    w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Registered port outputs; done/err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_ls   <= 1'b1;
            r_if_done   <= 1'b0;
            r_ls_done   <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_mem_start <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_size  <= SIZE_WORD;
            r_mem_op    <= 1'b0;
            r_mem_wdata <= '0;
            r_grant     <= 2'b00;
        end else begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_if) begin
                        r_mem_start <= 1'b1;
                        r_mem_addr  <= if_addr;
                        r_mem_size  <= SIZE_WORD;
                        r_mem_op    <= 1'b0;
                        r_mem_wdata <= '0;
                        r_grant     <= 2'b01;
                        r_last_ls   <= 1'b0;
                    end else if (w_grant_ls) begin
                        r_mem_start <= 1'b1;
                        r_mem_addr  <= ls_addr;
                        r_mem_size  <= ls_size;
                        r_mem_op    <= ls_op;
                        r_mem_wdata <= ls_wdata;
                        r_grant     <= 2'b10;
                        r_last_ls   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (mem_done) begin
                        r_mem_start <= 1'b0;
                        r_rdata     <= mem_rdata;
                        r_if_done   <= r_grant[0];
                        r_ls_done   <= r_grant[1];
                    end else if (w_timeout) begin
                        r_mem_start <= 1'b0;
                        r_rdata     <= '0;
                        r_if_done   <= r_grant[0];
                        r_ls_done   <= r_grant[1];
                        r_err       <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_grant <= 2'b00;
                end
                default: begin
                end
            endcase
        end
    end

    assign if_done   = r_if_done;
    assign ls_done   = r_ls_done;
    assign err       = r_err;
    assign rdata     = r_rdata;
    assign mem_start = r_mem_start;
    assign mem_addr  = r_mem_addr;
    assign mem_size  = r_mem_size;
    assign mem_op    = r_mem_op;
    assign mem_wdata = r_mem_wdata;
    assign grant     = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected requests/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 255;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          if_start;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic          ls_start;
    logic [AW-1:0] ls_addr;
    logic [1:0]    ls_size;
    logic          ls_op;
    logic [DW-1:0] ls_wdata;
    logic          ls_done;
    logic [DW-1:0] rdata;
    logic          mem_start;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_size;
    logic          mem_op;
    logic [DW-1:0] mem_wdata;
    logic          mem_done;
    logic [DW-1:0] mem_rdata;
    logic [1:0]    grant;
    logic          err;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .if_start(if_start), .if_addr(if_addr), .if_done(if_done),
        .ls_start(ls_start), .ls_addr(ls_addr), .ls_size(ls_size), .ls_op(ls_op),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .rdata(rdata),
        .mem_start(mem_start), .mem_addr(mem_addr), .mem_size(mem_size), .mem_op(mem_op),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_ls;
        logic [AW-1:0] addr;
        logic [1:0]    size;
        logic          op;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        logic          is_ls;
        logic [DW-1:0] rdata;
        logic          err;
    } done_t;

    req_t  exp_req_q[$];
    done_t exp_done_q[$];
    req_t  cur_req;
    logic  prev_start = 1'b0;
    int    n_pass  = 0;
    int    n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_if(input logic [AW-1:0] a);
        req_t r;
        r.is_ls = 1'b0; r.addr = a; r.size = 2'b10; r.op = 1'b0; r.wdata = '0;
        exp_req_q.push_back(r);
    endtask

    task automatic push_ls(input logic [AW-1:0] a, input logic [1:0] sz, input logic op,
                           input logic [DW-1:0] wd);
        req_t r;
        r.is_ls = 1'b1; r.addr = a; r.size = sz; r.op = op; r.wdata = wd;
        exp_req_q.push_back(r);
    endtask

    task automatic push_done(input logic is_ls, input logic [DW-1:0] rd, input logic e);
        done_t d;
        d.is_ls = is_ls; d.rdata = rd; d.err = e;
        exp_done_q.push_back(d);
    endtask

    // Monitor: request fields on mem_start rise and while held, completions on done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_start && !prev_start) begin
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_mem_req", 64'(1), 64'(0));
                end else begin
                    cur_req = exp_req_q.pop_front();
                    chk("req_grant", 64'(grant), cur_req.is_ls ? 64'(2) : 64'(1));
                    chk("req_addr", 64'(mem_addr), 64'(cur_req.addr));
                    chk("req_size", 64'(mem_size), 64'(cur_req.size));
                    chk("req_op", 64'(mem_op), 64'(cur_req.op));
                    if (cur_req.is_ls) chk("req_wdata", 64'(mem_wdata), 64'(cur_req.wdata));
                end
            end else if (mem_start) begin
                chk("stable_addr", 64'(mem_addr), 64'(cur_req.addr));
                chk("stable_size", 64'(mem_size), 64'(cur_req.size));
                chk("stable_op", 64'(mem_op), 64'(cur_req.op));
            end
            if (if_done || ls_done) begin
                if (exp_done_q.size() == 0) begin
                    chk("unexpected_done", 64'(1), 64'(0));
                end else begin
                    done_t d;
                    d = exp_done_q.pop_front();
                    chk("done_owner", 64'({ls_done, if_done}), d.is_ls ? 64'(2) : 64'(1));
                    chk("done_rdata", 64'(rdata), 64'(d.rdata));
                    chk("done_err", 64'(err), 64'(d.err));
                end
            end
        end
        prev_start = mem_start;
    end

    task automatic wait_done(input logic is_ls);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_ls ? ls_done : if_done) && n < 300);
        if (n >= 300) chk(is_ls ? "ls_done_wait" : "if_done_wait", 64'(0), 64'(1));
    endtask

    task automatic if_req(input logic [AW-1:0] a);
        if_addr  = a;
        if_start = 1'b1;
        wait_done(1'b0);
        @(posedge clk); #1;
        if_start = 1'b0;
    endtask

    task automatic ls_req(input logic [AW-1:0] a, input logic [1:0] sz, input logic op,
                          input logic [DW-1:0] wd);
        ls_addr  = a;
        ls_size  = sz;
        ls_op    = op;
        ls_wdata = wd;
        ls_start = 1'b1;
        wait_done(1'b1);
        @(posedge clk); #1;
        ls_start = 1'b0;
    endtask

    // Memory model: answer the next request dly cycles after mem_start is seen.
    task automatic mem_serve(input logic [DW-1:0] d, input int dly);
        int n = 0;
        while (!mem_start && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("mem_start_wait", 64'(0), 64'(1));
            return;
        end
        repeat (dly) @(posedge clk);
        #1;
        mem_done  = 1'b1;
        mem_rdata = d;
        @(posedge clk); #1;
        mem_done  = 1'b0;
        mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        chk("done_latency", 64'(if_done | ls_done), 64'(1));
        @(negedge clk);
        chk("release_quiet", 64'({if_done, ls_done, grant, mem_start}), 64'(0));
    endtask

    task automatic fetch_lat(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push_if(a);
        push_done(1'b0, d, 1'b0);
        @(posedge clk); #1;
        fork
            if_req(a);
            begin
                @(negedge clk);
                chk("pre_grant_mem_start", 64'(mem_start), 64'(0));
                @(negedge clk);
                chk("grant_latency", 64'(mem_start), 64'(1));
                mem_serve(d, 3);
            end
        join
    endtask

    initial begin
        reset = 1'b1; if_start = 1'b0; if_addr = '0; ls_start = 1'b0; ls_addr = '0;
        ls_size = 2'b00; ls_op = 1'b0; ls_wdata = '0; mem_done = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_size", 64'(mem_size), 64'(2));
        chk("rst_ctrl", 64'({mem_start, if_done, ls_done, grant, err, mem_op}), 64'(0));
        chk("rst_data", 64'(rdata | mem_addr | mem_wdata), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Single fetch
        fetch_lat(64'h1000, 64'h0050_0093);
        chk("fetch_rdata", 64'(rdata), 64'h0050_0093);

        // Single store
        push_ls(64'h2008, 2'b11, 1'b1, 64'hDEAD_BEEF);
        push_done(1'b1, 64'h1111, 1'b0);
        @(posedge clk); #1;
        fork
            ls_req(64'h2008, 2'b11, 1'b1, 64'hDEAD_BEEF);
            mem_serve(64'h1111, 2);
        join

        // Simultaneous after reset: IF first, then LS
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        push_if(64'h100);
        push_ls(64'h200, 2'b10, 1'b0, 64'h0);
        push_done(1'b0, 64'hAAAA_0001, 1'b0);
        push_done(1'b1, 64'hBBBB_0002, 1'b0);
        fork
            if_req(64'h100);
            ls_req(64'h200, 2'b10, 1'b0, 64'h0);
            begin mem_serve(64'hAAAA_0001, 1); mem_serve(64'hBBBB_0002, 1); end
        join

        // After a lone IF grant, a tie goes to LS then IF
        fetch_lat(64'h300, 64'hCCCC_0003);
        push_ls(64'h400, 2'b01, 1'b1, 64'h1234);
        push_if(64'h500);
        push_done(1'b1, 64'hDDDD_0004, 1'b0);
        push_done(1'b0, 64'hEEEE_0005, 1'b0);
        @(posedge clk); #1;
        fork
            if_req(64'h500);
            ls_req(64'h400, 2'b01, 1'b1, 64'h1234);
            begin mem_serve(64'hDDDD_0004, 2); mem_serve(64'hEEEE_0005, 2); end
        join

        // Field changes after grant are ignored
        push_ls(64'h2000, 2'b10, 1'b0, 64'h55);
        push_done(1'b1, 64'hF0F0_0006, 1'b0);
        @(posedge clk); #1;
        fork
            ls_req(64'h2000, 2'b10, 1'b0, 64'h55);
            begin
                int n = 0;
                while (!mem_start && n < 50) begin @(negedge clk); n++; end
                @(posedge clk); #1;
                ls_addr = 64'h3000; ls_size = 2'b00; ls_op = 1'b1; ls_wdata = 64'h77;
                @(negedge clk);
                chk("field_hold_addr", 64'(mem_addr), 64'h2000);
                chk("field_hold_wdata", 64'(mem_wdata), 64'h55);
            end
            mem_serve(64'hF0F0_0006, 4);
        join

        // Reset in the middle of ISSUE, then a stray mem_done
        push_if(64'h4000);
        @(posedge clk); #1;
        if_addr = 64'h4000; if_start = 1'b1;
        begin
            int n = 0;
            while (!mem_start && n < 50) begin @(negedge clk); n++; end
        end
        repeat (2) @(posedge clk);
        #1; reset = 1'b1; if_start = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctrl", 64'({mem_start, if_done, ls_done, grant}), 64'(0));
        chk("rst_mid_rdata", 64'(rdata), 64'(0));
        @(posedge clk); #1; mem_done = 1'b1; mem_rdata = 64'hBAD;
        @(posedge clk); #1; mem_done = 1'b0;
        @(negedge clk);
        chk("late_done_ignored", 64'({mem_start, if_done, ls_done, grant}), 64'(0));
        chk("late_done_rdata", 64'(rdata), 64'(0));
        fetch_lat(64'h5000, 64'h7777_0007);

        // rdata holds while idle
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("rdata_hold", 64'(rdata), 64'h7777_0007);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog fires after TO ISSUE cycles
        push_ls(64'h6000, 2'b01, 1'b1, 64'h99);
        push_done(1'b1, 64'h0, 1'b1);
        @(posedge clk); #1;
        fork
            ls_req(64'h6000, 2'b01, 1'b1, 64'h99);
            begin
                int n = 0;
                int k = 0;
                while (!mem_start && n < 20) begin @(negedge clk); n++; end
                while (mem_start && k < 50) begin k++; @(negedge clk); end
                chk("timeout_issue_cycles", 64'(k), 64'(TO));
                chk("timeout_done_err", 64'({ls_done, err}), 64'(3));
                chk("timeout_rdata", 64'(rdata), 64'(0));
            end
        join
        // mem_done on the timeout cycle wins
        push_ls(64'h7000, 2'b10, 1'b0, 64'h0);
        push_done(1'b1, 64'h8888_0008, 1'b0);
        @(posedge clk); #1;
        fork
            ls_req(64'h7000, 2'b10, 1'b0, 64'h0);
            mem_serve(64'h8888_0008, int'(TO) - 1);
        join
`else
        // Without the watchdog a slow memory is simply waited for
        push_ls(64'h6000, 2'b01, 1'b0, 64'h0);
        push_done(1'b1, 64'h9999_0009, 1'b0);
        @(posedge clk); #1;
        fork
            ls_req(64'h6000, 2'b01, 1'b0, 64'h0);
            mem_serve(64'h9999_0009, 40);
        join
`endif

        repeat (5) @(posedge clk);
        chk("req_queue_drained", 64'(exp_req_q.size()), 64'(0));
        chk("done_queue_drained", 64'(exp_done_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
